alu_mul_seq: RTL and testbench

//  Multi-cycle 32x32->64 unsigned shift-and-add multiplier controller.

---
 rtl/alu_mul_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_mul_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 shift-and-add multiplier that borrows the execute-stage ALU adder.
// Optional signed support (magnitude multiply plus 64-bit fix-up) is enabled by ALU_MUL_SIGNED_EN.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  output logic [1:0]       dbg_state
);

  // Handshake: a start is taken only on an edge where ready=1; done is a one-cycle
  // pulse with hi/lo valid, and ready returns the cycle after done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0]       ALU_ADD  = 3'b010;
  localparam logic [2:0]       ALU_NOP  = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               req_q, req_d;

  logic               accept;
  logic               carry;
  logic               fix_pending;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] fix_prod;

  assign accept = (state_q == S_IDLE) && start;

`ifdef ALU_MUL_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg_q, neg_d;

  assign mag_a    = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b    = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
  assign sgn_d    = accept ? signed_op : sgn_q;
  assign neg_d    = accept ? (signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) : neg_q;
  assign fix_pending = sgn_q;
  assign fix_prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
      neg_q <= neg_d;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign mag_a       = op_a;
  assign mag_b       = op_b;
  assign fix_pending = 1'b0;
  assign fix_prod    = {hi_q, lo_q};
`endif

  // The ALU sees a 32-bit add only; bit 32 is recovered from unsigned wrap-around.
  assign alu_a    = req_q ? hi_q : '0;
  assign alu_b    = (req_q && lo_q[0]) ? m_q : '0;
  assign alu_ctrl = req_q ? ALU_ADD : ALU_NOP;
  assign carry    = alu_res < alu_a;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = mag_a;
          hi_d    = '0;
          lo_d    = mag_b;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        hi_d  = {carry, alu_res[WIDTH-1:1]};
        lo_d  = {alu_res[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = fix_pending ? S_FIX : S_DONE;
        end
      end
      S_FIX: begin
        {hi_d, lo_d} = fix_prod;
        state_d      = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    req_d   = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      req_q   <= req_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign alu_req   = req_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: bench-side ALU adder, product/latency model with scoreboard,
// directed literal cases and randomized operands. Honours ALU_MUL_SIGNED_EN.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ready, done, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctrl;
  logic [1:0]  unused_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [63:0] exp_q[$];
  int          due_q[$];
  logic [31:0] exp_m_q[$];
  logic [63:0] held_p = '0;
  int          run_cnt = 0;

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .ready(ready), .done(done), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .dbg_state(unused_dbg_state)
  );

  // Stand-in for the execute-stage ALU: add when selected, junk otherwise.
  assign alu_res = (alu_ctrl == 3'b010) ? alu_a + alu_b : 32'hDEAD_BEEF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic use_signed(input logic s);
`ifdef ALU_MUL_SIGNED_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
    longint sa, sb;
    if (use_signed(s)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] model_mag(input logic [31:0] a, input logic s);
    if (use_signed(s) && a[31]) return 32'(0 - a);
    return a;
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      exp_m_q.delete();
      held_p  = '0;
      run_cnt = 0;
    end else begin
      if (alu_req) begin
        run_cnt++;
        chk("run_alu_ctrl", 64'(alu_ctrl), 64'(3'b010));
        chk("run_alu_a", 64'(alu_a), 64'(hi));
        if (exp_m_q.size() != 0)
          chk("run_alu_b", 64'(alu_b), lo[0] ? 64'(exp_m_q[0]) : 64'd0);
        chk("run_not_ready", 64'(ready), 64'd0);
      end else begin
        chk("idle_alu_bus", {29'b0, alu_ctrl, alu_a}, 64'd0);
        chk("idle_alu_b", 64'(alu_b), 64'd0);
      end
      if (done) begin
        chk("done_not_ready", 64'(ready), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
        end else begin
          chk("product", {hi, lo}, exp_q[0]);
          chk("latency", 64'(cyc), 64'(due_q[0]));
          chk("run_cycles", 64'(run_cnt), 64'd32);
          held_p = exp_q[0];
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
          void'(exp_m_q.pop_front());
        end
      end else if (due_q.size() != 0 && cyc > due_q[0]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no done expected done at cycle %0d", due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(exp_m_q.pop_front());
      end
      if (ready) begin
        chk("hold_hilo", {hi, lo}, held_p);
        chk("idle_no_req", 64'(alu_req), 64'd0);
        if (start) begin
          exp_q.push_back(model_prod(op_a, op_b, signed_op));
          due_q.push_back(cyc + 33 + int'(use_signed(signed_op)));
          exp_m_q.push_back(model_mag(op_a, signed_op));
          run_cnt = 0;
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int lat, output int t_acc);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_wait", 64'(ready), 64'd1);
    op_a = a; op_b = b; signed_op = s; start = 1'b1;
    t_acc = cyc;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; signed_op = 1'($urandom_range(0, 1));
    guard = 0;
    while (!done && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("done_wait", 64'(done), 64'd1);
    rh = hi; rl = lo;
    lat = cyc - t_acc;
  endtask

  logic [31:0] rh, rl;
  int lat, t0, t1, guard;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_outputs", {30'b0, done, alu_req, hi}, 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // 3 x 5
    do_op(32'd3, 32'd5, 1'b0, rh, rl, lat, t0);
    chk("t1_product", {rh, rl}, 64'd15);
    chk("t1_latency", 64'(lat), 64'd33);

    // carry path
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, lat, t0);
    chk("t2_product", {rh, rl}, 64'hFFFF_FFFE_0000_0001);

    // zero operand still runs full length
    do_op(32'd0, 32'h1234_5678, 1'b0, rh, rl, lat, t0);
    chk("zero_product", {rh, rl}, 64'd0);
    chk("zero_latency", 64'(lat), 64'd33);

    // starts while busy are ignored
    @(posedge clk); #1;
    op_a = 32'd7; op_b = 32'd9; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    guard = 0;
    while (!done && guard < 60) begin
      guard++;
      start = (guard == 5 || guard == 32);
      op_a = 32'd2; op_b = 32'd2;
      chk("t3_busy_ready", 64'(ready), 64'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_ready_at_done", 64'(ready), 64'd0);
    chk("t3_product", {hi, lo}, 64'd63);
    repeat (3) @(posedge clk);
    #1 chk("t3_no_second", {hi, lo}, 64'd63);

    // asynchronous reset during RUN
    op_a = 32'd11; op_b = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_ready", 64'(ready), 64'd1);
    chk("t4_req_done", {62'b0, alu_req, done}, 64'd0);
    chk("t4_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    do_op(32'd6, 32'd7, 1'b0, rh, rl, lat, t0);
    chk("t4_after_product", {rh, rl}, 64'd42);

    // back-to-back on first ready cycle
    t1 = cyc;
    @(posedge clk); #1;
    do_op(32'd100, 32'd200, 1'b0, rh, rl, lat, t0);
    chk("t5_accept_cycle", 64'(t0), 64'(t1 + 1));
    chk("t5_latency", 64'(lat), 64'd33);
    chk("t5_product", {rh, rl}, 64'd20000);

    // signed case
    @(posedge clk); #1;
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, rh, rl, lat, t0);
`ifdef ALU_MUL_SIGNED_EN
    chk("t6_product", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("t6_latency", 64'(lat), 64'd34);
`else
    chk("t6_product", {rh, rl}, 64'h0000_0004_FFFF_FFF1);
    chk("t6_latency", 64'(lat), 64'd33);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd1;
        1:       b = 32'h8000_0000;
        2:       b = 32'h7FFF_FFFF;
        default: b = $urandom;
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(a, b, 1'($urandom_range(0, 1)), rh, rl, lat, t0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500000ns");
    $fatal(1, "timeout");
  end

endmodule
